// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer for the logic-analyzer core.
// Merges the channel and protocol triggers into one trigger event, runs the
// pre-trigger / armed / post-trigger phases, drives the circular sample RAM
// write port and reports completion plus the oldest-sample address.
module capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_start,
    input  logic              clr_done,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [4:0]        CH_trig,
    input  logic              prot_trig,
    input  logic              smpl_en,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Counters carry one extra bit so that DEPTH itself is representable.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_tpos;       // trigger position latched at start
    logic [CNT_W-1:0]  r_smpl_cnt;   // writes taken during PRE
    logic [CNT_W-1:0]  r_post_cnt;   // writes still owed after the trigger
    logic              r_armed;
    logic              r_triggered;
    logic              r_done;

    logic              w_trig;
    logic              w_start;
    logic              w_write_ok;
    logic [CNT_W-1:0]  w_pre_cnt;
    logic [CNT_W-1:0]  w_smpl_cnt_inc;
    logic [ADDR_W-1:0] w_waddr_nxt;

    // Trigger event, start acceptance and write-enable qualification.
    // trig_pos is only ADDR_W bits wide, so it can never exceed DEPTH-1 and
    // the clamp to DEPTH-1 is inherent in the port width.
    always_comb begin
        w_trig         = (&CH_trig) & prot_trig;
        w_start        = capture_start & ((r_state == S_IDLE) | (r_state == S_DONE));
        // A POST phase with nothing left to write (zero trigger position)
        // must not take an extra sample on its way to DONE.
        w_write_ok     = (r_state == S_PRE) | (r_state == S_ARMED) |
                         ((r_state == S_POST) & (r_post_cnt != '0));
        w_pre_cnt      = CNT_W'(DEPTH) - {1'b0, r_tpos};
        w_smpl_cnt_inc = r_smpl_cnt + CNT_W'(1);
        w_waddr_nxt    = r_waddr + ADDR_W'(1);   // wraps DEPTH-1 -> 0 naturally
    end

    assign we           = smpl_en & w_write_ok;
    assign waddr        = r_waddr;
    assign armed        = r_armed;
    assign triggered    = r_triggered;
    assign capture_done = r_done;
    assign trig_addr    = r_trig_addr;

    // Capture sequencer: state, address, counters and registered flags.
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; blocking assignments would leak the
    // new value into later statements of the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_waddr     <= '0;
            r_trig_addr <= '0;
            r_tpos      <= '0;
            r_smpl_cnt  <= '0;
            r_post_cnt  <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_start) begin
            // Fresh capture from IDLE or straight out of DONE.
            r_state     <= S_PRE;
            r_waddr     <= '0;
            r_tpos      <= trig_pos;
            r_smpl_cnt  <= '0;
            r_post_cnt  <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_PRE: begin
                    if (we) begin
                        r_waddr    <= w_waddr_nxt;
                        r_smpl_cnt <= w_smpl_cnt_inc;
                        if (w_smpl_cnt_inc == w_pre_cnt) begin
                            r_state <= S_ARMED;
                            r_armed <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    // The buffer keeps overwriting its oldest entries here.
                    if (we) begin
                        r_waddr <= w_waddr_nxt;
                    end
                    if (w_trig) begin
                        r_state     <= S_POST;
                        r_triggered <= 1'b1;
                        r_post_cnt  <= {1'b0, r_tpos};
                    end
                end
                S_POST: begin
                    if (r_post_cnt == '0) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_trig_addr <= r_waddr;
                    end else if (we) begin
                        r_waddr    <= w_waddr_nxt;
                        r_post_cnt <= r_post_cnt - CNT_W'(1);
                        if (r_post_cnt == CNT_W'(1)) begin
                            // Next write address is the oldest sample.
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_trig_addr <= w_waddr_nxt;
                        end
                    end
                end
                S_DONE: begin
                    if (clr_done) begin
                        r_state     <= S_IDLE;
                        r_armed     <= 1'b0;
                        r_triggered <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                default: begin
                    // S_IDLE: hold until a start is accepted above.
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
